sqrt_odd_seq: RTL and testbench

Multi-cycle integer square root engine built on the odd-number subtraction method (n² = 1+3+…+(2n−1)) used by the combinational `sqrt_odd`. It replaces the combinational subtractor chain with one shared compare/subtract stage. A control FSM steps that stage once per clock. The block sits behind a START/BUSY/DONE handshake so a host sequencer can issue one root computation at a time and collect the root and remainder.

---
 rtl/sqrt_odd_seq_pkg.sv | 12 +
 rtl/sqrt_odd_seq_step.sv | 26 ++
 rtl/sqrt_odd_seq.sv | 114 +++++++++++
 tb/tb_sqrt_odd_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_odd_seq_pkg.sv
// rtl/sqrt_odd_seq_pkg.sv - shared state encodings and default width for the odd-subtraction square root engine
package sqrt_odd_seq_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_odd_seq_step.sv
// rtl/sqrt_odd_seq_step.sv - one compare/subtract step of the odd-number square root recurrence
module sqrt_odd_step #(
  parameter int W = 8
) (
  input  logic [W-1:0]   i_rem,
  input  logic [W/2:0]   i_odd,
  input  logic [W/2-1:0] i_cnt,
  output logic           o_ge,
  output logic [W-1:0]   o_rem,
  output logic [W/2:0]   o_odd,
  output logic [W/2-1:0] o_cnt
);

  localparam int OW = W / 2;
  localparam logic [OW:0]   ODD_STEP = (OW+1)'(2);
  localparam logic [OW-1:0] CNT_ONE  = OW'(1);

  logic [W-1:0] w_odd_ext;

  assign w_odd_ext = W'(i_odd);
  assign o_ge      = (i_rem >= w_odd_ext);
  assign o_rem     = i_rem - w_odd_ext;
  assign o_odd     = i_odd + ODD_STEP;
  assign o_cnt     = i_cnt + CNT_ONE;

endmodule

// File: rtl/sqrt_odd_seq.sv
// rtl/sqrt_odd_seq.sv - multi-cycle integer square root with START/BUSY/DONE handshake
module sqrt_odd_seq
  import sqrt_odd_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [W-1:0]   I,
  output logic           BUSY,
  output logic           DONE,
  output logic [W/2-1:0] O,
  output logic [W/2:0]   REM
);

  localparam int OW = W / 2;
  localparam logic [OW:0] ODD_ONE = (OW+1)'(1);

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_rem, w_rem_nxt;
  logic [OW:0]   r_odd, w_odd_nxt;
  logic [OW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [OW-1:0] r_o, w_o_nxt;
  logic [OW:0]   r_res_rem, w_res_rem_nxt;

  logic          w_ge;
  logic [W-1:0]  w_step_rem;
  logic [OW:0]   w_step_odd;
  logic [OW-1:0] w_step_cnt;

  sqrt_odd_step #(.W(W)) u_step (
    .i_rem (r_rem),
    .i_odd (r_odd),
    .i_cnt (r_cnt),
    .o_ge  (w_ge),
    .o_rem (w_step_rem),
    .o_odd (w_step_odd),
    .o_cnt (w_step_cnt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_odd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_o       <= '0;
      r_res_rem <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_odd     <= w_odd_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_o       <= w_o_nxt;
      r_res_rem <= w_res_rem_nxt;
    end
  end

  // Result registers only change on the CALC->DONE edge so O/REM hold between runs.
  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_odd_nxt     = r_odd;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_o_nxt       = r_o;
    w_res_rem_nxt = r_res_rem;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_CALC;
          w_rem_nxt   = I;
          w_odd_nxt   = ODD_ONE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_CALC: begin
        if (w_ge) begin
          w_rem_nxt = w_step_rem;
          w_odd_nxt = w_step_odd;
          w_cnt_nxt = w_step_cnt;
        end else begin
          w_state_nxt   = ST_DONE;
          w_done_nxt    = 1'b1;
          w_o_nxt       = r_cnt;
          w_res_rem_nxt = r_rem[OW:0];
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign O    = r_o;
  assign REM  = r_res_rem;

endmodule

// File: tb/tb_sqrt_odd_seq.sv
// tb/tb_sqrt_odd_seq.sv - self-checking bench for sqrt_odd_seq against a floor-sqrt reference
module tb_sqrt_odd_seq;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [7:0] I;
  logic       BUSY;
  logic       DONE;
  logic [3:0] O;
  logic [4:0] REM;

  int checks = 0;
  int errors = 0;

  sqrt_odd_seq #(.W(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .I     (I),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .O     (O),
    .REM   (REM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int ref_sqrt(input int v);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  task automatic run_one(input logic [7:0] val, output int lat, output logic [3:0] o,
                         output logic [4:0] r, output logic busy_ok, output logic idle_after);
    logic seen;
    @(negedge CLK);
    START = 1'b1;
    I     = val;
    @(posedge CLK);
    #1;
    START   = 1'b0;
    I       = 8'($urandom);
    lat     = 0;
    busy_ok = BUSY;
    seen    = 1'b0;
    o       = '0;
    r       = '0;
    while (!seen && lat < 300) begin
      @(posedge CLK);
      #1;
      lat++;
      if (!BUSY) busy_ok = 1'b0;
      if (DONE) begin
        seen = 1'b1;
        o    = O;
        r    = REM;
      end
    end
    if (!seen) lat = -1;
    @(posedge CLK);
    #1;
    idle_after = !BUSY && !DONE;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    START = 1'b0;
    I     = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({BUSY, DONE, O, REM} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b o=%0d rem=%0d want all 0", BUSY, DONE, O, REM);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_directed;
    logic [7:0] vals [4] = '{8'd0, 8'd56, 8'd9, 8'd255};
    int lat, s;
    logic [3:0] o;
    logic [4:0] r;
    logic bok, idl;
    foreach (vals[n]) begin
      run_one(vals[n], lat, o, r, bok, idl);
      s = ref_sqrt(int'(vals[n]));
      checks++;
      if (o !== 4'(s) || r !== 5'(int'(vals[n]) - s * s)) begin
        errors++;
        $display("FAIL directed_result I=%0d got o=%0d rem=%0d want o=%0d rem=%0d", vals[n], o, r, s, int'(vals[n]) - s * s);
      end
      checks++;
      if (lat != s + 1) begin
        errors++;
        $display("FAIL directed_latency I=%0d got %0d want %0d", vals[n], lat, s + 1);
      end
      checks++;
      if (!bok || !idl) begin
        errors++;
        $display("FAIL directed_busy I=%0d busy_during=%0b idle_after=%0b want 1 1", vals[n], bok, idl);
      end
      if (vals[n] == 8'd255) begin
        checks++;
        if (dut.r_odd !== 5'd31) begin
          errors++;
          $display("FAIL odd_no_wrap got %0d want 31", dut.r_odd);
        end
      end
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    logic seen;
    logic [3:0] o;
    logic [4:0] r;
    @(negedge CLK);
    START = 1'b1;
    I     = 8'd135;
    @(posedge CLK);
    #1;
    START = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    o     = '0;
    r     = '0;
    while (!seen && cyc < 100) begin
      START = (cyc == 2 || cyc == 5 || cyc == 9);
      if (START) I = 8'd4;
      @(posedge CLK);
      #1;
      cyc++;
      if (DONE) begin
        seen  = 1'b1;
        o     = O;
        r     = REM;
        START = 1'b1;
        I     = 8'd4;
      end
    end
    @(posedge CLK);
    #1;
    START = 1'b0;
    checks++;
    if (o !== 4'd11 || r !== 5'd14 || cyc != 12) begin
      errors++;
      $display("FAIL ignore_start got o=%0d rem=%0d lat=%0d want o=11 rem=14 lat=12", o, r, cyc);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_queued got busy=%0b want 0", BUSY);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, ndone;
    int t_done [3];
    logic [3:0] os [3];
    logic [4:0] rs [3];
    @(negedge CLK);
    START = 1'b1;
    I     = 8'd223;
    cyc   = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 100) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (DONE) begin
        t_done[ndone] = cyc;
        os[ndone]     = O;
        rs[ndone]     = REM;
        ndone++;
      end
    end
    START = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL held_start_count got %0d want 3", ndone);
    end else begin
      for (int n = 0; n < 3; n++) begin
        checks++;
        if (os[n] !== 4'd14 || rs[n] !== 5'd27) begin
          errors++;
          $display("FAIL held_start_result run=%0d got o=%0d rem=%0d want o=14 rem=27", n, os[n], rs[n]);
        end
      end
      for (int n = 1; n < 3; n++) begin
        checks++;
        if (t_done[n] - t_done[n-1] != 17) begin
          errors++;
          $display("FAIL held_start_period got %0d want 17", t_done[n] - t_done[n-1]);
        end
      end
    end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_async_reset;
    int lat;
    logic [3:0] o;
    logic [4:0] r;
    logic bok, idl;
    @(negedge CLK);
    START = 1'b1;
    I     = 8'd156;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, O, REM} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%0b done=%0b o=%0d rem=%0d want all 0", BUSY, DONE, O, REM);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    run_one(8'd46, lat, o, r, bok, idl);
    checks++;
    if (o !== 4'd6 || r !== 5'd10 || lat != 7) begin
      errors++;
      $display("FAIL after_reset got o=%0d rem=%0d lat=%0d want o=6 rem=10 lat=7", o, r, lat);
    end
  endtask

  task automatic test_sweep;
    int lat, s;
    logic [3:0] o;
    logic [4:0] r;
    logic bok, idl;
    for (int v = 0; v < 256; v++) begin
      run_one(8'(v), lat, o, r, bok, idl);
      s = ref_sqrt(v);
      checks++;
      if (o !== 4'(s) || r !== 5'(v - s * s) || lat != s + 1 || !bok || !idl) begin
        errors++;
        $display("FAIL sweep I=%0d got o=%0d rem=%0d lat=%0d busy=%0b idle=%0b want o=%0d rem=%0d lat=%0d",
                 v, o, r, lat, bok, idl, s, v - s * s, s + 1);
      end
    end
  endtask

  task automatic test_random;
    int lat, s, v;
    logic [3:0] o;
    logic [4:0] r;
    logic bok, idl;
    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(255, 0));
      run_one(8'(v), lat, o, r, bok, idl);
      s = ref_sqrt(v);
      checks++;
      if (o !== 4'(s) || r !== 5'(v - s * s) || lat != s + 1) begin
        errors++;
        $display("FAIL random I=%0d got o=%0d rem=%0d lat=%0d want o=%0d rem=%0d lat=%0d",
                 v, o, r, lat, s, v - s * s, s + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
